// File: rtl/aes512_block_packer.sv
// Ping-pong packer: gathers WORDS narrow stream words into a 512-bit block for the AES core.
// Short messages are zero-padded; each block carries its word count and an end-of-message flag.
module aes512_block_packer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned WORDS  = 512 / WORD_W,
    parameter int unsigned CNT_W  = $clog2(WORDS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [0:511]      blk_data,
    output logic              blk_valid,
    output logic              blk_last,
    output logic [CNT_W-1:0]  blk_words,
    input  logic              blk_ready
);

    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned SHIFT = $clog2(WORD_W);

    typedef enum logic [1:0] {BufEmpty, BufFilling, BufFull} buf_state_e;

    buf_state_e             state_q [2];
    buf_state_e             state_d [2];
    logic       [0:511]     buf_q   [2];
    logic       [0:511]     buf_d   [2];
    logic                   last_q  [2];
    logic                   last_d  [2];
    logic       [CNT_W-1:0] cnt_q   [2];
    logic       [CNT_W-1:0] cnt_d   [2];
    logic                   wsel_q, wsel_d;
    logic                   rsel_q, rsel_d;
    logic       [IDX_W-1:0] widx_q, widx_d;

    logic       accept;
    logic       release_blk;
    logic       complete;
    logic [8:0] bit_off;

    // Handshake and output views come straight from registered state: no ready-to-ready path.
    always_comb begin
        in_ready    = (state_q[wsel_q] != BufFull);
        blk_valid   = (state_q[rsel_q] == BufFull);
        blk_data    = buf_q[rsel_q];
        blk_last    = last_q[rsel_q];
        blk_words   = cnt_q[rsel_q];
        accept      = in_valid && in_ready;
        release_blk = blk_valid && blk_ready;
        complete    = accept && ((widx_q == IDX_W'(WORDS - 1)) || in_last);
        // WORD_W is a power of two, so the word's bit offset is widx scaled by a shift.
        bit_off     = 9'({widx_q, {SHIFT{1'b0}}});
    end

    // Next-state: release of rsel and fill of wsel are independent; they never hit the same
    // buffer in one cycle because a FULL write buffer holds in_ready low.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wsel_d  = wsel_q;
        rsel_d  = rsel_q;
        widx_d  = widx_q;

        if (release_blk) begin
            state_d[rsel_q] = BufEmpty;
            buf_d[rsel_q]   = '0;
            last_d[rsel_q]  = 1'b0;
            cnt_d[rsel_q]   = '0;
            rsel_d          = ~rsel_q;
        end

        if (accept) begin
            buf_d[wsel_q][bit_off +: WORD_W] = in_data;
            state_d[wsel_q] = BufFilling;
            widx_d          = widx_q + IDX_W'(1);
            if (complete) begin
                state_d[wsel_q] = BufFull;
                last_d[wsel_q]  = in_last;
                cnt_d[wsel_q]   = CNT_W'(widx_q) + CNT_W'(1);
                wsel_d          = ~wsel_q;
                widx_d          = '0;
            end
        end
    end

    // State registers; reset empties and zeroes both buffers so padding is always zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= BufEmpty;
                buf_q[i]   <= '0;
                last_q[i]  <= 1'b0;
                cnt_q[i]   <= '0;
            end
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            widx_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                buf_q[i]   <= buf_d[i];
                last_q[i]  <= last_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            widx_q <= widx_d;
        end
    end

endmodule

// File: doc/aes512_block_packer.md
# aes512_block_packer

Upstream stage of the 512-bit AES encryption datapath. Accepts a narrow word stream with a valid/ready handshake, assembles WORDS consecutive words into one 512-bit block, and presents it to the 512-bit encryption core's data input with its own valid/ready handshake. Double-buffered (ping-pong), so one block can be filled while the previous one waits for the consumer. Short final blocks are zero-padded and flagged.

## Interface

- WORD_W, default 32: input word width. Legal values are 8, 16, 32 and 64.
- WORDS, default 512/WORD_W: words per block. Derived; do not override.
- CNT_W, default $clog2(WORDS)+1: width of blk_words.

- clk  input  1  single clock; all flops on the rising edge.
- rst_n  input  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously to clk.
- in_data  input  WORD_W  stream word.
- in_valid  input  1  in_data (and in_last) are valid.
- in_last  input  1  this word is the final word of the message.
- in_ready  output  1  packer can accept a word this cycle.
- blk_data  output  [0:511]  assembled block, bit 0 = MSB. Drives the encryption core data input directly.
- blk_valid  output  1  blk_data, blk_last and blk_words are valid.
- blk_last  output  1  block ends the message (in_last was seen).
- blk_words  output  CNT_W  count of received words in the block, range 1..WORDS.
- blk_ready  input  1  consumer accepts the block this cycle.

## Operation

- Two buffers, B0 and B1. Each buffer has a state (EMPTY, FILLING, FULL), a last flag and a word count.
- Write pointer wsel and read pointer rsel both start at B0.
- Input word index widx runs 0..WORDS-1.
- Word placement: accepted word k goes to bits [k*WORD_W +: WORD_W] of the block.
  - The first word lands in bits [0:WORD_W-1].
  - Within a word, the word's MSB maps to the lower block index.
  - The packer performs no byte reordering. Byte de-interleaving is the core's job.
- in_ready = (state[wsel] != FULL). It is a function of registered state only, with no combinational path from blk_ready.
- Accept is in_valid && in_ready. On accept:
  - Write the word.
  - Set state[wsel] to FILLING.
  - Increment widx.
- Block completion happens on an accept where widx == WORDS-1 or in_last == 1. On completion:
  - state[wsel] becomes FULL.
  - Latch last = in_last and count = widx+1.
  - Toggle wsel.
  - Reset widx to 0.
- in_last on word WORDS-1 completes a full block with blk_last=1.
- in_last before WORDS words: the remaining word slots stay zero, because buffers are zeroed when released and at reset.
- Output side:
  - blk_valid = (state[rsel] == FULL).
  - blk_data, blk_last and blk_words come from buffer rsel.
- Release is blk_valid && blk_ready. On release:
  - state[rsel] becomes EMPTY.
  - The buffer's data is cleared to 0 and its flags are cleared.
  - rsel toggles.
- Simultaneous events:
  - Release of buffer rsel and completion or accept into buffer wsel in the same cycle are independent when wsel != rsel. Both take effect.
  - When wsel == rsel and that buffer is FULL, in_ready is 0, so no write can collide with the release. The next cycle in_ready is 1.
- Once blk_valid is asserted, blk_data, blk_last and blk_words hold stable until release (AXI-style). in_valid high with in_ready low must not lose or duplicate a word.
- in_last with no preceding partial block produces a 1-word block: blk_words=1, words 1..WORDS-1 = 0.

## Timing

- Reset values:
  - in_ready=1, blk_valid=0, blk_last=0, blk_words=0, blk_data=0.
  - All buffers EMPTY and zeroed; wsel=rsel=0; widx=0.
- Reset mid-operation discards all partial and full blocks immediately. No block is emitted for pre-reset words.
- Latency: completing accept at edge N gives blk_valid=1 after edge N (visible in cycle N+1).
- Release at edge M gives blk_valid low after M, unless the other buffer is already FULL. In that case blk_valid stays 1 and the next block is presented in cycle M+1 with no bubble.
- Throughput: sustained one word per cycle (WORDS cycles per block) while the consumer releases each block within WORDS cycles of its presentation.
- Backpressure: with both buffers FULL, in_ready=0 until the edge after the first release.

## Test plan

- Reset, then 16 words 0x00000000..0x0000000F back-to-back with in_last on word 15, blk_ready=1 -> one block, blk_data[480:511]=0x0000000F, blk_data[0:31]=0, blk_last=1, blk_words=16, blk_valid rises the cycle after word 15.
- Stream 3 words 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC with in_last on the third -> blk_data[0:95]=AAAAAAAA_BBBBBBBB_CCCCCCCC, bits [96:511]=0, blk_words=3, blk_last=1.
- blk_ready=0, stream 40 continuous words -> two FULL blocks, in_ready drops after word 32, word 33 is held. Raise blk_ready -> blocks emitted in order with no gap, word 33 accepted the cycle after the first release, no loss or duplication (scoreboard).
- Random in_valid/blk_ready toggling over 1000 words with random in_last -> output equals the reference packing model; blk_* stable whenever blk_valid && !blk_ready.
- Assert rst_n low for 1 cycle mid-block (word 7 of block 2, block 1 still FULL) -> blk_valid=0 and in_ready=1 immediately. The next 16 words form a clean block with no stale data.
- Single word 0x12345678 with in_last -> blk_words=1, blk_data[0:31]=0x12345678, rest 0. The following block after release shows zeros in unwritten slots.
